// File: rtl/add_share_ctrl_if.sv
// add_share_ctrl_if -- bundle of the two requester channels and the response
// channel of add_share_ctrl.
//   reqN_valid/reqN_ready : requester N handshake
//   reqN_a/reqN_b         : operands, W = 16*WORDS bits
//   reqN_sub              : 1 = a-b, 0 = a+b
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id                : index of the requester that owns the result
//   rsp_sum               : W-bit result (modulo 2^W)
//   rsp_cout              : carry out of the MSB (for subtract, 1 = no borrow)
//   rsp_ovf               : two's-complement signed overflow
// master: requesters plus result consumer. slave: the adder block.
interface add_share_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/add_share_ctrl.sv
// add_share_ctrl -- one 16-bit carry-lookahead adder shared by two requesters.
// A W-bit (W = 16*WORDS) add or subtract is done serially, one 16-bit slice per
// cycle, so an operation takes WORDS cycles from accept to result. Requesters
// are arbitrated round-robin while idle; only one operation is ever in flight.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : add_share_ctrl_if.slave (requests in, response out)
module add_share_ctrl #(
  parameter int WORDS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  add_share_ctrl_if.slave bus
);
  localparam int W     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;        // requester served most recently
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;        // b already inverted for subtract

  logic             grant0, grant1;
  logic [17:0]      slice_res;             // {carry out, carry into bit 15, sum}

  // 16-bit carry-lookahead add: every carry is a flat sum of generate terms
  // propagated through the bits above them, with no ripple chain.
  function automatic logic [17:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic        term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[16], c[15], p ^ c[15:0]};
  endfunction

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
  end

  assign bus.req0_ready = rst_n & (state_q == IDLE) & grant0;
  assign bus.req1_ready = rst_n & (state_q == IDLE) & grant1;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_ovf   = ovf_q;

  assign slice_res = cla16(op_a_q[{idx_q, 4'b0000} +: 16],
                           op_b_q[{idx_q, 4'b0000} +: 16], carry_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    id_d        = id_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    rsp_valid_d = rsp_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          // Subtract is a + ~b + 1: the +1 enters as the initial carry.
          id_d    = grant1;
          op_a_d  = grant1 ? bus.req1_a : bus.req0_a;
          op_b_d  = grant1 ? (bus.req1_b ^ {W{bus.req1_sub}})
                           : (bus.req0_b ^ {W{bus.req0_sub}});
          carry_d = grant1 ? bus.req1_sub : bus.req0_sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[{idx_q, 4'b0000} +: 16] = slice_res[15:0];
        carry_d = slice_res[17];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d      = slice_res[17];
          ovf_d       = slice_res[17] ^ slice_res[16];
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_d      = id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, result and handshake state; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Operand holding registers: only read in CALC after an accept loads them.
  always_ff @(posedge clk) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
  end
endmodule

// File: tb/tb_add_share_ctrl.sv
module tb_add_share_ctrl;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_share_ctrl_if #(.WORDS(WORDS)) bus();

  add_share_ctrl #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           acc_cyc[$];
  bit           acc_id[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           nacc     = 0;
  int           nrsp     = 0;
  bit           last_served = 1'b1;
  bit           prev_v   = 1'b0;
  logic         last_id;
  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain W-bit integer arithmetic on the operands.
  function automatic exp_t model(input logic id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sub, input int due);
    exp_t            e;
    logic signed [W:0] sa, sb, sr;
    logic [W:0]      ua;
    sa = $signed({a[W-1], a});
    sb = $signed({b[W-1], b});
    sr = sub ? (sa - sb) : (sa + sb);
    ua = {1'b0, a} + {1'b0, b};
    e.id   = id;
    e.sum  = sub ? (a - b) : (a + b);
    e.cout = sub ? (a >= b) : ua[W];
    e.ovf  = sr[W] ^ sr[W-1];
    e.due  = due;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      4:       v = W'($urandom_range(0, 3));
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Request side: check the grant and push the expected result on accept.
  always @(negedge clk) begin
    logic r0, r1, v0, v1, eg;
    if (rst_n) begin
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      v0 = bus.req0_valid; v1 = bus.req1_valid;
      if (r0 | r1) begin
        eg = (v0 && v1) ? ~last_served : v1;
        chk("grant_id", r1, eg);
        chk("grant_onehot", r0 & r1, 0);
        chk("ready_while_busy", sbq.size(), 0);
        if (r1) sbq.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_sub, cyc + 1 + WORDS));
        else    sbq.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_sub, cyc + 1 + WORDS));
        acc_cyc.push_back(cyc);
        acc_id.push_back(r1);
        nacc++;
      end
    end
  end

  // Response monitor: compare every presented response with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      last_served = 1'b1;
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected actual=1 required=0");
        end else begin
          e = sbq[0];
          if (!prev_v) chk("latency", cyc, e.due);
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_sum", bus.rsp_sum, e.sum);
          chk("rsp_cout", bus.rsp_cout, e.cout);
          chk("rsp_ovf", bus.rsp_ovf, e.ovf);
          if (bus.rsp_ready) begin
            last_served = e.id;
            last_id   = bus.rsp_id;
            last_sum  = bus.rsp_sum;
            last_cout = bus.rsp_cout;
            last_ovf  = bus.rsp_ovf;
            nrsp++;
            void'(sbq.pop_front());
          end
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic set_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input bit id);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        @(posedge clk); #1;
        if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 1, 0);
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nrsp >= target) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("rsp_timeout", nrsp, target);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s, nr;
    bus.req0_valid = 1'b1; bus.req0_a = 64'h0000_0000_0000_FFFF; bus.req0_b = 64'h1; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.rsp_ready  = 1'b1;

    // Reset held two cycles with req0 asking.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_sum", bus.rsp_sum, 0);
      chk("rst_rsp_cout", bus.rsp_cout, 0);
      chk("rst_rsp_ovf", bus.rsp_ovf, 0);
    end
    chk("rst_no_accept", nacc, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req0_ready", bus.req0_ready, 1);

    // Add carrying across a slice boundary.
    wait_accept(0);
    wait_rsp(1);
    chk("add_sum", last_sum, 64'h0000_0000_0001_0000);
    chk("add_cout", last_cout, 0);
    chk("add_ovf", last_ovf, 0);
    chk("add_id", last_id, 0);

    // Subtract with borrow, then signed overflow.
    set_req(1, 64'h0, 64'h1, 1'b1);
    wait_accept(1);
    wait_rsp(2);
    chk("sub_sum", last_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_cout", last_cout, 0);
    chk("sub_ovf", last_ovf, 0);
    chk("sub_id", last_id, 1);
    set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_accept(1);
    wait_rsp(3);
    chk("ovf_sum", last_sum, 64'h8000_0000_0000_0000);
    chk("ovf_cout", last_cout, 0);
    chk("ovf_ovf", last_ovf, 1);

    // Fairness: both requesters continuously valid.
    s = nacc;
    set_req(0, 64'h1234, 64'h5678, 1'b0);
    set_req(1, 64'h9999, 64'h1111, 1'b1);
    for (int i = 0; i < 60 && nacc < s + 4; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("fair_accepts", nacc >= s + 4, 1);
    if (nacc >= s + 4) begin
      for (int i = 0; i < 4; i++) chk("fair_id", acc_id[s+i], i % 2);
      for (int i = 1; i < 4; i++) chk("fair_spacing", acc_cyc[s+i] - acc_cyc[s+i-1], WORDS + 2);
    end
    wait_rsp(nacc);

    // Backpressure: hold the response for five cycles.
    bus.rsp_ready = 1'b0;
    set_req(0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    wait_accept(0);
    set_req(0, rnd_op(), rnd_op(), 1'b0);
    set_req(1, rnd_op(), rnd_op(), 1'b1);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_readies", bus.req0_ready | bus.req1_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_after_ack", bus.req0_ready | bus.req1_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_rsp(nacc);

    // Abort: reset during the second CALC cycle.
    set_req(0, rnd_op(), rnd_op(), 1'b0);
    for (int i = 0; i < 20 && !bus.req0_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nr = nrsp;
    repeat (10) @(negedge clk);
    chk("abort_no_rsp", nrsp, nr);
    @(posedge clk); #1;
    set_req(1, rnd_op(), rnd_op(), 1'b1);
    wait_accept(1);
    wait_rsp(nr + 1);

    // Randomized traffic with random valids and response backpressure.
    s = nacc;
    for (int c = 0; c < 3000 && nacc < s + 40; c++) begin
      @(posedge clk); #1;
      if (!bus.req0_valid || $urandom_range(0, 4) == 0) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req0_a = rnd_op(); bus.req0_b = rnd_op(); bus.req0_sub = 1'($urandom_range(0, 1));
      end
      if (!bus.req1_valid || $urandom_range(0, 4) == 0) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req1_a = rnd_op(); bus.req1_b = rnd_op(); bus.req1_sub = 1'($urandom_range(0, 1));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_accepts", nacc >= s + 40, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/add_share_ctrl.md
ADD_SHARE_CTRL -- requirements
Module: add_share_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS, default 4, giving the number of 16-bit slices per operation; the operand width W = 16*WORDS.
REQ-002 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each: requester asserts an operation.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 each: block accepts the operation this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W each: operands.
REQ-007 The block SHALL have ports req0_sub / req1_sub, input, 1 each: 1 = a-b, 0 = a+b.
REQ-008 The block SHALL have port rsp_valid, output, 1: result available.
REQ-009 The block SHALL have port rsp_ready, input, 1: consumer takes the result.
REQ-010 The block SHALL have port rsp_id, output, 1: requester index of the result.
REQ-011 The block SHALL have port rsp_sum, output, W: result.
REQ-012 The block SHALL have port rsp_cout, output, 1: carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 The block SHALL have port rsp_ovf, output, 1: two's-complement signed overflow.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CALC, RESP.
REQ-015 In IDLE, grant is combinational: with one valid, grant it; with both valid, grant the requester not served last; the last-served pointer resets to 1, so req0 wins the first tie.
REQ-016 reqN_ready SHALL be 1 only in IDLE for the granted requester; it SHALL be 0 in CALC and RESP.
REQ-017 On accept (valid & ready), the block SHALL latch a, b^{W{sub}}, carry = sub and id; it SHALL clear the slice index and go to CALC.
REQ-018 Each CALC cycle SHALL do one 16-bit carry-lookahead add of slice[idx] plus the carry register, write sum slice idx, update carry, and increment idx.
REQ-019 After slice WORDS-1, the block SHALL capture rsp_cout = final carry and rsp_ovf = carry-into-MSB XOR carry-out-of-MSB, then go to RESP.
REQ-020 Latency: rsp_valid SHALL be 1 exactly WORDS cycles after the accept edge.
REQ-021 RESP: rsp_valid = 1, and rsp_id/rsp_sum/rsp_cout/rsp_ovf SHALL stay stable until rsp_ready = 1.
REQ-022 When rsp_valid & rsp_ready, the block SHALL go to IDLE and set the last-served pointer to rsp_id.
REQ-023 Arbitration happens only in IDLE, so minimum spacing between accepts is WORDS+2 cycles.
REQ-024 Request inputs SHALL be ignored outside IDLE; deasserting valid before accept loses nothing and reorders nothing.
REQ-025 Arithmetic is modulo 2^W; there SHALL be no saturation.
REQ-026 The block SHALL have no internal queue: at most one operation is in flight.

Reset
REQ-027 When rst_n = 0 at a clk edge, state SHALL go to IDLE, last-served to 1, and idx, carry and result registers to 0.
REQ-028 In reset, rsp_valid, rsp_id, rsp_sum, rsp_cout and rsp_ovf SHALL be 0, and req0_ready/req1_ready SHALL be 0 while rst_n = 0.
REQ-029 Reset in CALC or RESP SHALL abort the operation; no response is produced for it.

Verification
REQ-030 Reset: hold rst_n = 0 for 2 cycles with req0_valid = 1 -> all outputs 0 and no accept; the first cycle after release gives req0_ready = 1.
REQ-031 Add: req0 a=0x0000_0000_0000_FFFF, b=0x1, sub=0 -> 4 cycles later rsp_valid = 1, sum=0x0000_0000_0001_0000, cout=0, ovf=0, id=0.
REQ-032 Sub/overflow: req1 a=0, b=1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0; then a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-033 Fairness: both valid continuously with rsp_ready = 1 -> rsp_id sequence 0,1,0,1 and accepts 6 cycles apart.
REQ-034 Backpressure: rsp_ready = 0 for 5 cycles in RESP -> rsp_* stable, both readies 0; when rsp_ready = 1 for one cycle, IDLE follows the next cycle.
REQ-035 Abort: assert rst_n = 0 for 1 cycle in the 2nd CALC cycle -> rsp_valid never asserts for that operation; a new request then completes normally.
